sigma_delta_dac: RTL
====================

// Module: sigma_delta_dac
// PURPOSE
// - Final DAC stage. Consumes the 8x-interpolated 16-bit signed stream from the serial FIR (out/rdy).
// - Converts it with a 2nd-order sigma-delta modulator to a 1-bit pulse-density output for an RC-filtered pin.
// - Modulator updates every clk; input sample held between strobes.
// - Detects starvation and input clipping.
// PARAMETERS
// - WIDTH    16     input sample width (signed two's complement)
// - LIMIT    28672  input clamp magnitude, |x| <= LIMIT (0.875 FS, keeps loop stable)
// - TIMEOUT  256    clk cycles without sample_ready before STARVED
// PORTS
// - clk           in   1      system clock; all logic on posedge
// - rst_n         in   1      asynchronous, active-low reset
// - sample        in   WIDTH  signed sample (connects to FIR out)
// - sample_ready  in   1      1-cycle strobe, sample valid (connects to FIR rdy)
// - mute          in   1      level; forces modulator input to 0 while high
// - dac_out       out  1      registered 1-bit PDM output
// - underrun      out  1      high while in STARVED state
// - clip          out  1      1-cycle pulse when a strobed sample was clamped
// BEHAVIOUR
// - Reset (async, rst_n=0): int1=int2=0, x_reg=0, dac_out=0, underrun=0, clip=0, tmo_cnt=0, state=IDLE.
//   Reset mid-run clears all of these immediately, without waiting for a clk edge.
// - Input latch on posedge with sample_ready=1:
//   - x_reg = clamp(sample, -LIMIT, +LIMIT).
//   - clip=1 on the next cycle iff clamping occurred, else 0.
//   - tmo_cnt=0.
// - Modulator input: xm = (mute || state!=RUN) ? 0 : x_reg.
// - Feedback: fb = dac_out ? +2^(WIDTH-1) : -2^(WIDTH-1).
// - Per clk, CIFB:
//   - int1 += xm - fb; int1 is WIDTH+2 bits, saturating at +/-(2^(WIDTH+1)-1).
//   - int2 += int1 - fb; int2 is WIDTH+4 bits, saturating at +/-(2^(WIDTH+3)-1). Uses the pre-update int1.
//   - dac_out <= (int2_next >= 0).
// - Latency: a sample strobed at edge N affects int1 at edge N+1 and dac_out at N+2.
// - FSM:
//   - IDLE: xm=0; first sample_ready -> RUN.
//   - RUN: tmo_cnt increments each cycle without a strobe; tmo_cnt==TIMEOUT-1 with no strobe -> STARVED.
//   - STARVED: underrun=1, xm=0, integrators keep running (idle 50% density); sample_ready -> RUN.
//     underrun falls on the same edge the sample is latched.
// - Simultaneous strobe and timeout edge: the strobe wins; stay in RUN, tmo_cnt=0.
// - tmo_cnt saturates at TIMEOUT-1; never wraps.
// - mute does not affect FSM, tmo_cnt or clip; it only zeroes xm.
// - sample_ready on consecutive cycles is legal; each cycle overwrites x_reg.
// CONFIGURATION
// - SIGMA_DELTA_DITHER_EN defined:
//   - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 on reset, advances every clk.
//   - Bit 0 of the LFSR adds +1/-1 to the int2 update; this breaks idle tones.
// - Undefined: no LFSR; int2 update is exactly as above.
// TESTING
// - Reset: rst_n low mid-run with dac_out=1 -> dac_out, underrun, clip, int1, int2 read 0 with no clk edge.
// - Zero input: one strobe of 0, hold 1024 cycles -> count(dac_out)=512+/-2; with dither off, pattern is 1010...
// - Half scale: strobe +16384, refresh every 8 cycles -> ones density 75%+/-1% over 4096 cycles; clip never pulses.
// - Clamp: strobe 32767 -> clip=1 for exactly 1 cycle, x_reg=28672, density 93.75%+/-1%.
//   Strobe -32768 -> x_reg=-28672.
// - Starvation: last strobe at cycle 0 -> underrun rises at cycle TIMEOUT (256), density returns to 50%.
//   Strobe at cycle 300 -> underrun=0 at that edge.
// - Mute/collision: mute=1 with x_reg=+16384 -> 50% density, underrun unaffected.
//   Strobe on the timeout edge -> underrun stays 0.

Source files
------------

// File: rtl/sigma_delta_dac.sv
// Final DAC stage: 2nd-order CIFB sigma-delta modulator that turns the interpolated 16-bit stream into 1-bit PDM.
// Optional build macro SIGMA_DELTA_DITHER_EN adds LFSR +/-1 dither to the second integrator.
module sigma_delta_dac #(
    parameter int WIDTH   = 16,
    parameter int LIMIT   = 28672,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] sample,
    input  logic                    sample_ready,
    input  logic                    mute,
    output logic                    dac_out,
    output logic                    underrun,
    output logic                    clip
);

    localparam int I1W  = WIDTH + 2;
    localparam int I2W  = WIDTH + 4;
    localparam int SUMW = I2W + 2;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FS   = 2 ** (WIDTH - 1);

    localparam logic signed [WIDTH-1:0] POS_LIM  = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] NEG_LIM  = WIDTH'(-LIMIT);
    localparam logic signed [SUMW-1:0]  FB_POS   = SUMW'(FS);
    localparam logic signed [SUMW-1:0]  FB_NEG   = SUMW'(-FS);
    localparam logic signed [SUMW-1:0]  I1_MAX   = SUMW'(2 ** (I1W - 1) - 1);
    localparam logic signed [SUMW-1:0]  I1_MIN   = SUMW'(-(2 ** (I1W - 1) - 1));
    localparam logic signed [SUMW-1:0]  I2_MAX   = SUMW'(2 ** (I2W - 1) - 1);
    localparam logic signed [SUMW-1:0]  I2_MIN   = SUMW'(-(2 ** (I2W - 1) - 1));
    localparam logic [TW-1:0]           TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } state_t;

    state_t                  state;
    logic [TW-1:0]           tmo_cnt;
    logic signed [WIDTH-1:0] x_reg;
    logic signed [I1W-1:0]   int1;
    logic signed [I2W-1:0]   int2;

    logic signed [WIDTH-1:0] sample_clamped;
    logic                    clamped;
    logic signed [WIDTH-1:0] xm;
    logic signed [SUMW-1:0]  fb_ext;
    logic signed [SUMW-1:0]  dither;
    logic signed [SUMW-1:0]  sum1;
    logic signed [SUMW-1:0]  sum2;
    logic signed [I1W-1:0]   int1_nxt;
    logic signed [I2W-1:0]   int2_nxt;

    // sample_ready is a one-cycle valid strobe with no back-pressure: every strobed
    // sample is accepted on that edge and replaces the held value.
    always_comb begin
        clamped        = 1'b0;
        sample_clamped = sample;
        if (sample > POS_LIM) begin
            clamped        = 1'b1;
            sample_clamped = POS_LIM;
        end else if (sample < NEG_LIM) begin
            clamped        = 1'b1;
            sample_clamped = NEG_LIM;
        end
    end

`ifdef SIGMA_DELTA_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign dither = lfsr[0] ? SUMW'(1) : SUMW'(-1);
`else
    assign dither = '0;
`endif

    // Integrators only see the held sample while actively fed; idle and starved run on zero.
    always_comb begin
        xm     = (mute || state != RUN) ? '0 : x_reg;
        fb_ext = dac_out ? FB_POS : FB_NEG;
        sum1   = SUMW'(int1) + SUMW'(xm) - fb_ext;
        sum2   = SUMW'(int2) + SUMW'(int1) - fb_ext + dither;

        if (sum1 > I1_MAX) begin
            int1_nxt = I1W'(I1_MAX);
        end else if (sum1 < I1_MIN) begin
            int1_nxt = I1W'(I1_MIN);
        end else begin
            int1_nxt = I1W'(sum1);
        end

        if (sum2 > I2_MAX) begin
            int2_nxt = I2W'(I2_MAX);
        end else if (sum2 < I2_MIN) begin
            int2_nxt = I2W'(I2_MIN);
        end else begin
            int2_nxt = I2W'(sum2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1     <= '0;
            int2     <= '0;
            dac_out  <= 1'b0;
            x_reg    <= '0;
            clip     <= 1'b0;
            underrun <= 1'b0;
            tmo_cnt  <= '0;
            state    <= IDLE;
        end else begin
            int1    <= int1_nxt;
            int2    <= int2_nxt;
            dac_out <= ~int2_nxt[I2W-1];

            // A strobe always wins, including on the edge that would otherwise time out.
            if (sample_ready) begin
                x_reg    <= sample_clamped;
                clip     <= clamped;
                tmo_cnt  <= '0;
                state    <= RUN;
                underrun <= 1'b0;
            end else begin
                clip <= 1'b0;
                case (state)
                    RUN: begin
                        if (tmo_cnt == TMO_LAST) begin
                            state    <= STARVED;
                            underrun <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
